multicycle_ctrl: RTL and testbench

Multi-cycle sequencing controller for the CPU datapath: replaces the single-cycle decode path with a state machine that steps each instruction through fetch, decode, execute, memory and write-back. It handles wait-stated instruction and data memories through a req/ready handshake and enforces a bounded wait timeout. It emits the same datapath control set (regWrite, memWrite, waControl, wdControl, aluSrc, branch, jump, aluControl, signExtSignal), now gated per state.

---
 rtl/multicycle_ctrl.sv | 252 +++++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multi-cycle CPU sequencer: FETCH/DECODE/EXEC/MEM/WB with req/ready handshakes and a bounded wait timeout.
// Define MULTICYCLE_ILLEGAL_TRAP_EN to trap illegal instructions in TRAP; otherwise they retire as NOPs.
`ifndef OP_SIZE
`define OP_SIZE 6
`endif
`ifndef ALUCONTROL_SIZE
`define ALUCONTROL_SIZE 4
`endif
`ifndef EXTENDSIGNAL_SIZE
`define EXTENDSIGNAL_SIZE 2
`endif
`ifndef ALU_NONE
`define ALU_NONE 4'b0000
`endif
`ifndef ALU_ADD
`define ALU_ADD 4'b0010
`endif
`ifndef ALU_SUB
`define ALU_SUB 4'b0110
`endif
`ifndef ALU_SRAV
`define ALU_SRAV 4'b1011
`endif

module multicycle_ctrl #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [`OP_SIZE-1:0]             opcode,
    input  logic [`OP_SIZE-1:0]             funcode,
    input  logic                            alu_zero,
    input  logic                            imem_ready,
    input  logic                            dmem_ready,
    output logic                            imem_req,
    output logic                            dmem_req,
    output logic                            ir_we,
    output logic                            pc_we,
    output logic                            regWrite,
    output logic                            memWrite,
    output logic                            waControl,
    output logic                            wdControl,
    output logic                            aluSrc,
    output logic                            branch,
    output logic                            jump,
    output logic [`ALUCONTROL_SIZE-1:0]     aluControl,
    output logic [`EXTENDSIGNAL_SIZE-1:0]   signExtSignal,
    output logic                            instr_done,
    output logic                            bus_err,
    output logic                            illegal
);

    localparam logic [`OP_SIZE-1:0] OP_RTYPE = 6'b000000;
    localparam logic [`OP_SIZE-1:0] OP_ADDI  = 6'b001000;
    localparam logic [`OP_SIZE-1:0] OP_ADDIU = 6'b001001;
    localparam logic [`OP_SIZE-1:0] OP_LUI   = 6'b001111;
    localparam logic [`OP_SIZE-1:0] OP_LW    = 6'b100011;
    localparam logic [`OP_SIZE-1:0] OP_SW    = 6'b101011;
    localparam logic [`OP_SIZE-1:0] OP_BEQ   = 6'b000100;
    localparam logic [`OP_SIZE-1:0] OP_J     = 6'b000010;
    localparam logic [`OP_SIZE-1:0] FN_ADD   = 6'b100000;
    localparam logic [`OP_SIZE-1:0] FN_SRAV  = 6'b000111;

    localparam logic [`EXTENDSIGNAL_SIZE-1:0] EXT_NONE = 2'b00;
    localparam logic [`EXTENDSIGNAL_SIZE-1:0] EXT_SIGN = 2'b01;
    localparam logic [`EXTENDSIGNAL_SIZE-1:0] EXT_LUI  = 2'b10;

    // Abort fires on the cycle that would make the wait count reach TIMEOUT_CYCLES.
    localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        TRAP
    } stateType;

    stateType   state;
    stateType   nextState;
    logic [7:0] waitCnt;
    logic [7:0] waitCntNext;

    logic isRType, isAdd, isSrav, isAddi, isAddiu, isLui, isLw, isSw, isBeq, isJ, isLegal;
    logic [`ALUCONTROL_SIZE-1:0]   aluDec;
    logic                          aluSrcDec;
    logic [`EXTENDSIGNAL_SIZE-1:0] extDec;
    logic fetchWait, memWait, timeoutHit;

    assign isRType = (opcode == OP_RTYPE);
    assign isAdd   = isRType && (funcode == FN_ADD);
    assign isSrav  = isRType && (funcode == FN_SRAV);
    assign isAddi  = (opcode == OP_ADDI);
    assign isAddiu = (opcode == OP_ADDIU);
    assign isLui   = (opcode == OP_LUI);
    assign isLw    = (opcode == OP_LW);
    assign isSw    = (opcode == OP_SW);
    assign isBeq   = (opcode == OP_BEQ);
    assign isJ     = (opcode == OP_J);
    assign isLegal = isAdd | isSrav | isAddi | isAddiu | isLui | isLw | isSw | isBeq | isJ;

    always_comb begin
        aluDec    = `ALU_NONE;
        aluSrcDec = 1'b0;
        extDec    = EXT_NONE;
        if (isAdd) begin
            aluDec = `ALU_ADD;
        end else if (isSrav) begin
            aluDec = `ALU_SRAV;
        end else if (isAddi || isAddiu || isLw || isSw) begin
            aluDec    = `ALU_ADD;
            aluSrcDec = 1'b1;
            extDec    = EXT_SIGN;
        end else if (isLui) begin
            aluSrcDec = 1'b1;
            extDec    = EXT_LUI;
        end else if (isBeq) begin
            aluDec = `ALU_SUB;
            extDec = EXT_SIGN;
        end
    end

    // Timeout is derived from state alone so the output decode below stays loop-free.
    assign fetchWait  = (state == FETCH) && !imem_ready;
    assign memWait    = (state == MEM) && !dmem_ready;
    assign timeoutHit = (fetchWait || memWait) && (waitCnt == WAIT_LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            waitCnt <= 8'd0;
        end else begin
            state   <= nextState;
            waitCnt <= waitCntNext;
        end
    end

    always_comb begin
        waitCntNext = waitCnt;
        if (timeoutHit || (nextState != state)) begin
            waitCntNext = 8'd0;
        end else if (fetchWait || memWait) begin
            waitCntNext = waitCnt + 8'd1;
        end
    end

    always_comb begin
        nextState     = state;
        imem_req      = 1'b0;
        dmem_req      = 1'b0;
        ir_we         = 1'b0;
        pc_we         = 1'b0;
        regWrite      = 1'b0;
        memWrite      = 1'b0;
        waControl     = 1'b0;
        wdControl     = 1'b0;
        aluSrc        = 1'b0;
        branch        = 1'b0;
        jump          = 1'b0;
        aluControl    = `ALU_NONE;
        signExtSignal = EXT_NONE;
        instr_done    = 1'b0;
        bus_err       = 1'b0;
        case (state)
            IDLE: nextState = FETCH;
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_we     = 1'b1;
                    pc_we     = 1'b1;
                    nextState = DECODE;
                end else if (timeoutHit) begin
                    // Retry the same PC: no ir_we/pc_we on abort.
                    bus_err   = 1'b1;
                    nextState = FETCH;
                end
            end
            DECODE: begin
                if (isJ) begin
                    jump       = 1'b1;
                    pc_we      = 1'b1;
                    instr_done = 1'b1;
                    nextState  = FETCH;
                end else if (!isLegal) begin
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
                    nextState  = TRAP;
`else
                    instr_done = 1'b1;
                    nextState  = FETCH;
`endif
                end else begin
                    nextState = EXEC;
                end
            end
            EXEC: begin
                aluControl    = aluDec;
                aluSrc        = aluSrcDec;
                signExtSignal = extDec;
                if (isBeq) begin
                    branch     = 1'b1;
                    pc_we      = alu_zero;
                    instr_done = 1'b1;
                    nextState  = FETCH;
                end else if (isLw || isSw) begin
                    nextState = MEM;
                end else begin
                    nextState = WB;
                end
            end
            MEM: begin
                // ALU controls held so the memory address stays valid through wait states.
                aluControl    = aluDec;
                aluSrc        = aluSrcDec;
                signExtSignal = extDec;
                dmem_req      = 1'b1;
                memWrite      = isSw;
                if (dmem_ready) begin
                    if (isSw) begin
                        instr_done = 1'b1;
                        nextState  = FETCH;
                    end else begin
                        nextState = WB;
                    end
                end else if (timeoutHit) begin
                    bus_err   = 1'b1;
                    nextState = FETCH;
                end
            end
            WB: begin
                aluControl    = aluDec;
                aluSrc        = aluSrcDec;
                signExtSignal = extDec;
                regWrite      = 1'b1;
                waControl     = isRType;
                wdControl     = isLw;
                instr_done    = 1'b1;
                nextState     = FETCH;
            end
            TRAP: nextState = TRAP;
            default: nextState = IDLE;
        endcase
    end

`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    assign illegal = (state == TRAP);
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed scenarios plus randomized instruction/wait-state mix
// checked against a per-instruction behavioural model (cycle count, control pulses, ALU encodings).
`timescale 1ns/1ps
module tb_multicycle_ctrl;

    localparam logic [3:0] A_NONE = 4'b0000;
    localparam logic [3:0] A_ADD  = 4'b0010;
    localparam logic [3:0] A_SUB  = 4'b0110;
    localparam logic [3:0] A_SRAV = 4'b1011;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [5:0] opcode = '0, funcode = '0;
    logic alu_zero = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0;
    logic imem_req, dmem_req, ir_we, pc_we, regWrite, memWrite, waControl, wdControl;
    logic aluSrc, branch, jump, instr_done, bus_err, illegal;
    logic [3:0] aluControl;
    logic [1:0] signExtSignal;

    multicycle_ctrl #(.TIMEOUT_CYCLES(15)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funcode(funcode), .alu_zero(alu_zero),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(imem_req), .dmem_req(dmem_req),
        .ir_we(ir_we), .pc_we(pc_we), .regWrite(regWrite), .memWrite(memWrite),
        .waControl(waControl), .wdControl(wdControl), .aluSrc(aluSrc), .branch(branch), .jump(jump),
        .aluControl(aluControl), .signExtSignal(signExtSignal), .instr_done(instr_done),
        .bus_err(bus_err), .illegal(illegal)
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nFails = 0;

    typedef struct {
        int base;
        bit legal, wr, wa, wd, ld, st, j, beq;
        logic [3:0] alu;
        logic src;
        logic [1:0] ext;
    } expT;

    // Reference: what each instruction must do, straight from the instruction set description.
    function automatic expT model(input logic [5:0] op, input logic [5:0] fn);
        expT e;
        e.base = 2; e.legal = 1; e.wr = 0; e.wa = 0; e.wd = 0; e.ld = 0; e.st = 0;
        e.j = 0; e.beq = 0; e.alu = A_NONE; e.src = 0; e.ext = 2'b00;
        if (op == 6'b000000 && fn == 6'b100000) begin
            e.base = 4; e.wr = 1; e.wa = 1; e.alu = A_ADD;
        end else if (op == 6'b000000 && fn == 6'b000111) begin
            e.base = 4; e.wr = 1; e.wa = 1; e.alu = A_SRAV;
        end else if (op == 6'b001000 || op == 6'b001001) begin
            e.base = 4; e.wr = 1; e.alu = A_ADD; e.src = 1; e.ext = 2'b01;
        end else if (op == 6'b001111) begin
            e.base = 4; e.wr = 1; e.src = 1; e.ext = 2'b10;
        end else if (op == 6'b100011) begin
            e.base = 5; e.wr = 1; e.wd = 1; e.ld = 1; e.alu = A_ADD; e.src = 1; e.ext = 2'b01;
        end else if (op == 6'b101011) begin
            e.base = 4; e.st = 1; e.alu = A_ADD; e.src = 1; e.ext = 2'b01;
        end else if (op == 6'b000100) begin
            e.base = 3; e.beq = 1; e.alu = A_SUB; e.ext = 2'b01;
        end else if (op == 6'b000010) begin
            e.j = 1;
        end else begin
            e.legal = 0;
        end
        return e;
    endfunction

    int obsCycles, obsDone, obsDoneCyc, obsBusErr, obsRegWr, obsRegWrCyc, obsMemWr, obsDreq;
    int obsPcWe, obsIrWe, obsJump, obsBranch, obsBoth, obsIllegal;
    logic obsWa, obsWd, obsSrc;
    logic [3:0] obsAlu;
    logic [1:0] obsExt;

    // Drives one instruction from FETCH until retirement or abort; ready arrives after the given wait counts.
    task automatic runInstr(input logic [5:0] op, input logic [5:0] fn, input int iwait, input int dwait,
                            input logic zero);
        int iSeen = 0;
        int dSeen = 0;
        bit stop = 0;
        obsCycles = 0; obsDone = 0; obsDoneCyc = 0; obsBusErr = 0; obsRegWr = 0; obsRegWrCyc = 0;
        obsMemWr = 0; obsDreq = 0; obsPcWe = 0; obsIrWe = 0; obsJump = 0; obsBranch = 0;
        obsBoth = 0; obsIllegal = 0; obsWa = 0; obsWd = 0; obsSrc = 0; obsAlu = 'x; obsExt = 'x;
        opcode = op; funcode = fn; alu_zero = zero;
        for (int c = 1; c <= 64 && !stop; c++) begin
            imem_ready = imem_req && (iSeen == iwait);
            dmem_ready = dmem_req && (dSeen == dwait);
            #1;
            if (imem_req) iSeen++;
            if (dmem_req) begin dSeen++; obsDreq++; end
            if (memWrite) obsMemWr++;
            if (pc_we) obsPcWe++;
            if (ir_we) obsIrWe++;
            if (jump) obsJump++;
            if (branch) obsBranch++;
            if (illegal) obsIllegal++;
            if (imem_req && dmem_req) obsBoth++;
            if (regWrite) begin obsRegWr++; obsRegWrCyc = c; obsWa = waControl; obsWd = wdControl; end
            if (c == iwait + 3) begin obsAlu = aluControl; obsSrc = aluSrc; obsExt = signExtSignal; end
            if (instr_done) begin obsDone++; obsDoneCyc = c; end
            if (bus_err) obsBusErr++;
            if (instr_done || bus_err) begin obsCycles = c; stop = 1; end
            @(negedge clk);
        end
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        nChecks++;
        if ({imem_req, dmem_req, ir_we, pc_we, regWrite, memWrite, waControl, wdControl, aluSrc, branch,
             jump, aluControl, signExtSignal, instr_done, bus_err, illegal} !== '0) begin
            nFails++; $display("FAIL reset_outputs: got nonzero outputs, required all 0");
        end
        nChecks++;
        if (aluControl !== A_NONE) begin nFails++; $display("FAIL reset_alu: got %b, required %b", aluControl, A_NONE); end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        #1;
        nChecks++;
        if (imem_req !== 1'b0) begin nFails++; $display("FAIL idle_no_req: got %b, required 0", imem_req); end
        @(negedge clk);
        #1;
        nChecks++;
        if (imem_req !== 1'b1) begin nFails++; $display("FAIL fetch_after_idle: got %b, required 1", imem_req); end
    endtask

    task automatic test_add();
        runInstr(6'b000000, 6'b100000, 0, 0, 1'b0);
        nChecks++;
        if (obsDoneCyc !== 4) begin nFails++; $display("FAIL add_done_cycle: got %0d, required 4", obsDoneCyc); end
        nChecks++;
        if (obsRegWr !== 1 || obsRegWrCyc !== 4) begin
            nFails++; $display("FAIL add_regwrite: got %0d pulses at %0d, required 1 at 4", obsRegWr, obsRegWrCyc);
        end
        nChecks++;
        if (obsWa !== 1'b1) begin nFails++; $display("FAIL add_wacontrol: got %b, required 1", obsWa); end
        nChecks++;
        if (obsAlu !== A_ADD) begin nFails++; $display("FAIL add_alu: got %b, required %b", obsAlu, A_ADD); end
    endtask

    task automatic test_lw_wait();
        runInstr(6'b100011, 6'b000000, 0, 3, 1'b0);
        nChecks++;
        if (obsCycles !== 8) begin nFails++; $display("FAIL lw_cycles: got %0d, required 8", obsCycles); end
        nChecks++;
        if (obsDreq !== 4) begin nFails++; $display("FAIL lw_dmem_req: got %0d cycles, required 4", obsDreq); end
        nChecks++;
        if (obsMemWr !== 0) begin nFails++; $display("FAIL lw_memwrite: got %0d, required 0", obsMemWr); end
        nChecks++;
        if (obsWd !== 1'b1 || obsRegWr !== 1) begin
            nFails++; $display("FAIL lw_wb: got wd=%b regWrite=%0d, required wd=1 regWrite=1", obsWd, obsRegWr);
        end
    endtask

    task automatic test_beq();
        for (int z = 1; z >= 0; z--) begin
            runInstr(6'b000100, 6'b000000, 0, 0, z[0]);
            nChecks++;
            if (obsCycles !== 3) begin nFails++; $display("FAIL beq%0d_cycles: got %0d, required 3", z, obsCycles); end
            nChecks++;
            if (obsPcWe !== 1 + z) begin nFails++; $display("FAIL beq%0d_pc_we: got %0d, required %0d", z, obsPcWe, 1 + z); end
            nChecks++;
            if (obsBranch !== 1) begin nFails++; $display("FAIL beq%0d_branch: got %0d, required 1", z, obsBranch); end
        end
    endtask

    task automatic test_timeout();
        runInstr(6'b000000, 6'b100000, 255, 0, 1'b0);
        nChecks++;
        if (obsBusErr !== 1 || obsCycles !== 15) begin
            nFails++; $display("FAIL fetch_timeout: got bus_err=%0d at %0d, required 1 at 15", obsBusErr, obsCycles);
        end
        nChecks++;
        if (obsIrWe !== 0 || obsPcWe !== 0 || obsDone !== 0) begin
            nFails++; $display("FAIL fetch_abort_writes: got ir_we=%0d pc_we=%0d done=%0d, required 0", obsIrWe, obsPcWe, obsDone);
        end
        #1;
        nChecks++;
        if (imem_req !== 1'b1) begin nFails++; $display("FAIL fetch_retry: got imem_req=%b, required 1", imem_req); end
        runInstr(6'b000000, 6'b100000, 14, 0, 1'b0);
        nChecks++;
        if (obsBusErr !== 0 || obsCycles !== 18) begin
            nFails++; $display("FAIL ready_wins: got bus_err=%0d cycles=%0d, required 0 and 18", obsBusErr, obsCycles);
        end
        runInstr(6'b100011, 6'b000000, 0, 255, 1'b0);
        nChecks++;
        if (obsBusErr !== 1 || obsCycles !== 18) begin
            nFails++; $display("FAIL mem_timeout: got bus_err=%0d at %0d, required 1 at 18", obsBusErr, obsCycles);
        end
        nChecks++;
        if (obsRegWr !== 0 || obsDone !== 0) begin
            nFails++; $display("FAIL mem_abort_drop: got regWrite=%0d done=%0d, required 0", obsRegWr, obsDone);
        end
    endtask

    task automatic test_random();
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
        logic [11:0] pool [9] = '{12'o0040, 12'o0007, 12'o1000, 12'o1100, 12'o1700, 12'o4300, 12'o5300,
                                  12'o0400, 12'o0200};
`else
        logic [11:0] pool [11] = '{12'o0040, 12'o0007, 12'o1000, 12'o1100, 12'o1700, 12'o4300, 12'o5300,
                                   12'o0400, 12'o0200, 12'o7700, 12'o0042};
`endif
        for (int n = 0; n < 40; n++) begin
            logic [11:0] pick;
            int iw, dw, expCyc, expPc;
            logic z;
            expT e;
            pick = pool[$urandom_range($size(pool) - 1)];
            iw = $urandom_range(3);
            dw = $urandom_range(3);
            z = 1'($urandom_range(1));
            e = model(pick[11:6], pick[5:0]);
            expCyc = e.base + iw + ((e.ld || e.st) ? dw : 0);
            expPc = 1 + int'(e.j) + int'(e.beq && z);
            runInstr(pick[11:6], pick[5:0], iw, dw, z);
            nChecks++;
            if (obsCycles !== expCyc || obsDone !== 1 || obsBusErr !== 0) begin
                nFails++; $display("FAIL rnd%0d_retire op=%o: got cycles=%0d done=%0d err=%0d, required %0d/1/0",
                                   n, pick, obsCycles, obsDone, obsBusErr, expCyc);
            end
            nChecks++;
            if (obsRegWr !== int'(e.wr) || (e.wr && (obsWa !== e.wa || obsWd !== e.wd))) begin
                nFails++; $display("FAIL rnd%0d_wb op=%o: got rw=%0d wa=%b wd=%b, required rw=%0d wa=%b wd=%b",
                                   n, pick, obsRegWr, obsWa, obsWd, e.wr, e.wa, e.wd);
            end
            nChecks++;
            if (obsDreq !== ((e.ld || e.st) ? dw + 1 : 0) || obsMemWr !== (e.st ? dw + 1 : 0)) begin
                nFails++; $display("FAIL rnd%0d_mem op=%o: got dreq=%0d memWrite=%0d, dwait=%0d",
                                   n, pick, obsDreq, obsMemWr, dw);
            end
            nChecks++;
            if (obsPcWe !== expPc || obsIrWe !== 1 || obsJump !== int'(e.j) || obsBranch !== int'(e.beq)) begin
                nFails++; $display("FAIL rnd%0d_pc op=%o: got pc_we=%0d ir_we=%0d jump=%0d branch=%0d, required pc_we=%0d",
                                   n, pick, obsPcWe, obsIrWe, obsJump, obsBranch, expPc);
            end
            nChecks++;
            if (obsBoth !== 0 || obsIllegal !== 0) begin
                nFails++; $display("FAIL rnd%0d_excl: got both_req=%0d illegal=%0d, required 0", n, obsBoth, obsIllegal);
            end
            if (e.base >= 3) begin
                nChecks++;
                if (obsAlu !== e.alu || obsSrc !== e.src || obsExt !== e.ext) begin
                    nFails++; $display("FAIL rnd%0d_alu op=%o: got %b/%b/%b, required %b/%b/%b",
                                       n, pick, obsAlu, obsSrc, obsExt, e.alu, e.src, e.ext);
                end
            end
        end
    endtask

    task automatic test_reset_mid_sw();
        bit seen = 0;
        opcode = 6'b101011; funcode = 6'b000000;
        for (int c = 0; c < 20 && !seen; c++) begin
            imem_ready = 1'b1; dmem_ready = 1'b0;
            #1;
            if (dmem_req) seen = 1;
            else @(negedge clk);
        end
        nChecks++;
        if (!seen || memWrite !== 1'b1) begin
            nFails++; $display("FAIL sw_reach_mem: got seen=%0d memWrite=%b, required 1/1", seen, memWrite);
        end
        rst_n = 1'b0;
        #1;
        nChecks++;
        if ({imem_req, dmem_req, ir_we, pc_we, regWrite, memWrite, waControl, wdControl, aluSrc, branch,
             jump, aluControl, signExtSignal, instr_done, bus_err, illegal} !== '0) begin
            nFails++; $display("FAIL reset_mid_sw: got memWrite=%b dmem_req=%b alu=%b, required all 0", memWrite, dmem_req, aluControl);
        end
        @(negedge clk);
        rst_n = 1'b1; imem_ready = 1'b0;
        #1;
        nChecks++;
        if (imem_req !== 1'b0 || memWrite !== 1'b0) begin
            nFails++; $display("FAIL post_reset_idle: got imem_req=%b memWrite=%b, required 0/0", imem_req, memWrite);
        end
        @(negedge clk);
        #1;
        nChecks++;
        if (imem_req !== 1'b1 || memWrite !== 1'b0 || dmem_req !== 1'b0) begin
            nFails++; $display("FAIL post_reset_fetch: got imem_req=%b memWrite=%b dmem_req=%b, required 1/0/0",
                               imem_req, memWrite, dmem_req);
        end
    endtask

    task automatic test_illegal();
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
        opcode = 6'b111111; funcode = 6'b000000;
        imem_ready = 1'b1;
        @(negedge clk);
        imem_ready = 1'b0;
        @(negedge clk);
        for (int c = 0; c < 4; c++) begin
            imem_ready = c[0]; dmem_ready = c[1];
            #1;
            nChecks++;
            if (illegal !== 1'b1 || {imem_req, dmem_req, ir_we, pc_we, regWrite, memWrite, instr_done, bus_err,
                                     jump, branch} !== '0) begin
                nFails++; $display("FAIL trap_hold%0d: got illegal=%b imem_req=%b instr_done=%b, required 1/0/0",
                                   c, illegal, imem_req, instr_done);
            end
            @(negedge clk);
        end
`else
        runInstr(6'b111111, 6'b000000, 0, 0, 1'b0);
        nChecks++;
        if (obsCycles !== 2 || obsDone !== 1) begin
            nFails++; $display("FAIL illegal_nop: got cycles=%0d done=%0d, required 2/1", obsCycles, obsDone);
        end
        nChecks++;
        if (obsIllegal !== 0 || obsRegWr !== 0 || obsMemWr !== 0 || obsPcWe !== 1) begin
            nFails++; $display("FAIL illegal_nop_side: got illegal=%0d rw=%0d mw=%0d pc_we=%0d, required 0/0/0/1",
                               obsIllegal, obsRegWr, obsMemWr, obsPcWe);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_add();
        test_lw_wait();
        test_beq();
        test_timeout();
        test_random();
        test_reset_mid_sw();
        test_illegal();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
